// File: rtl/uart_program_loader_pkg.sv
// Shared constants for the UART program loader: FSM encodings, UART frame levels, default baud divisor.
package loader_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DATA_BITS = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL = 1'b1;

  localparam logic [2:0] ST_CNT_HI = 3'd0;
  localparam logic [2:0] ST_CNT_LO = 3'd1;
  localparam logic [2:0] ST_DAT_HI = 3'd2;
  localparam logic [2:0] ST_DAT_LO = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_CHK    = 3'd6;

  typedef enum logic [2:0] {
    CNT_HI = ST_CNT_HI,
    CNT_LO = ST_CNT_LO,
    DAT_HI = ST_DAT_HI,
    DAT_LO = ST_DAT_LO,
    WRITE  = ST_WRITE,
    DONE   = ST_DONE,
    CHK    = ST_CHK
  } loader_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_program_loader_uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling, glitch rejection on the start bit.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       ferr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]       sync_reg;
  logic             rx_prev_reg;
  logic             rx_s;
  rx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic             valid_reg, valid_next;
  logic             ferr_reg, ferr_next;

  assign rx_s = sync_reg[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg    <= 2'b11;
      rx_prev_reg <= 1'b1;
      state_reg   <= RX_IDLE;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      shift_reg   <= '0;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[0], rx};
      rx_prev_reg <= rx_s;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_reg     <= bit_next;
      shift_reg   <= shift_next;
      valid_reg   <= valid_next;
      ferr_reg    <= ferr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    case (state_reg)
      RX_IDLE: begin
        cnt_next = '0;
        if (rx_prev_reg == STOP_LEVEL && rx_s == START_LEVEL) state_next = RX_START;
      end
      RX_START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          bit_next   = '0;
          // A start bit that is already high again at mid-bit was line noise
          state_next = (rx_s == START_LEVEL) ? RX_DATA : RX_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[7:1]};
          if (bit_reg == 3'(DATA_BITS - 1)) state_next = RX_STOP;
          else bit_next = bit_reg + 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s == STOP_LEVEL) begin
            valid_next = 1'b1;
            state_next = RX_IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = RX_WAIT_HIGH;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s == STOP_LEVEL) state_next = RX_IDLE;
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign rx_data    = shift_reg;
  assign byte_valid = valid_reg;
  assign ferr       = ferr_reg;

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives a word-count-prefixed image over UART, writes it to memory port B, then releases the CPU.
// Optional trailing XOR checksum byte when UART_LOADER_CHECKSUM_EN is defined.
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_b,
  output logic              we_b,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  logic [7:0]        rx_data;
  logic              byte_valid;
  logic              ferr;
  loader_state_t     state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic [7:0]        cnt_hi_reg, cnt_hi_next;
  logic              we_reg, we_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              cpu_rst_reg, cpu_rst_next;
  logic [31:0]       n_words;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]        chk_reg, chk_next;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .byte_valid (byte_valid),
    .ferr       (ferr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= CNT_HI;
      addr_reg    <= '0;
      data_reg    <= '0;
      count_reg   <= '0;
      cnt_hi_reg  <= '0;
      we_reg      <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      cpu_rst_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      data_reg    <= data_next;
      count_reg   <= count_next;
      cnt_hi_reg  <= cnt_hi_next;
      we_reg      <= we_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      cpu_rst_reg <= cpu_rst_next;
    end
  end

`ifdef UART_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chk_reg <= '0;
    else     chk_reg <= chk_next;
  end
`endif

  assign n_words = {16'd0, cnt_hi_reg, rx_data};

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    data_next    = data_reg;
    count_next   = count_reg;
    cnt_hi_next  = cnt_hi_reg;
    we_next      = 1'b0;
    done_next    = done_reg;
    err_next     = err_reg;
    cpu_rst_next = cpu_rst_reg;
`ifdef UART_LOADER_CHECKSUM_EN
    chk_next     = chk_reg;
`endif
    // A framing error leaves the state untouched so the sender can resend the byte
    if (ferr && state_reg != DONE) err_next = 1'b1;
    case (state_reg)
      CNT_HI: if (byte_valid) begin
        cnt_hi_next = rx_data;
        state_next  = CNT_LO;
      end
      CNT_LO: if (byte_valid) begin
`ifdef UART_LOADER_CHECKSUM_EN
        chk_next = '0;
`endif
        if (n_words == 32'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
          state_next = CHK;
`else
          state_next = DONE;
`endif
        end else if (n_words > MAX_WORDS) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          count_next = n_words[ADDR_W:0];
          state_next = DAT_HI;
        end
      end
      DAT_HI: if (byte_valid) begin
        data_next  = {rx_data, data_reg[DATA_W/2-1:0]};
`ifdef UART_LOADER_CHECKSUM_EN
        chk_next   = chk_reg ^ rx_data;
`endif
        state_next = DAT_LO;
      end
      DAT_LO: if (byte_valid) begin
        data_next  = {data_reg[DATA_W-1:DATA_W/2], rx_data};
`ifdef UART_LOADER_CHECKSUM_EN
        chk_next   = chk_reg ^ rx_data;
`endif
        we_next    = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        addr_next  = addr_reg + 1'b1;
        count_next = count_reg - 1'b1;
        if (count_reg == (ADDR_W+1)'(1)) begin
`ifdef UART_LOADER_CHECKSUM_EN
          state_next = CHK;
`else
          state_next = DONE;
`endif
        end else begin
          state_next = DAT_HI;
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      CHK: if (byte_valid) begin
        if (rx_data != chk_reg) err_next = 1'b1;
        state_next = DONE;
      end
`endif
      DONE: begin
        // The CPU is only released on a clean load
        if (!err_reg) cpu_rst_next = 1'b0;
      end
      default: state_next = CNT_HI;
    endcase
    if (state_next == DONE) done_next = 1'b1;
  end

  assign addr_b  = addr_reg;
  assign data_b  = data_reg;
  assign we_b    = we_reg;
  assign done    = done_reg;
  assign err     = err_reg;
  assign cpu_rst = cpu_rst_reg;

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomised bench for uart_program_loader: serialises frames on rx and checks port-B writes and status against a frame-level model.
module tb_uart_program_loader;

  localparam int CPB = 16;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int MAXW = 1 << ADDR_W;

  typedef logic [7:0] byte_q_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx = 1'b1;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] data_b;
  logic              we_b;
  logic              cpu_rst;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .addr_b  (addr_b),
    .data_b  (data_b),
    .we_b    (we_b),
    .cpu_rst (cpu_rst),
    .done    (done),
    .err     (err)
  );

  // Monitor: logs every write, counts multi-cycle we_b pulses, timestamps done rise / cpu_rst fall
  logic [31:0] wr_q[$];
  int          we_run_err = 0;
  longint      cyc = 0;
  longint      done_rise = -1;
  longint      cpu_fall = -1;
  logic        we_prev = 1'b0;
  logic        done_prev = 1'b0;
  logic        cpu_prev = 1'b1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      we_prev   = 1'b0;
      done_prev = 1'b0;
      cpu_prev  = 1'b1;
      done_rise = -1;
      cpu_fall  = -1;
    end else begin
      if (we_b) wr_q.push_back({16'(addr_b), data_b});
      if (we_b && we_prev) we_run_err = we_run_err + 1;
      if (done && !done_prev) done_rise = cyc;
      if (!cpu_rst && cpu_prev) cpu_fall = cyc;
      we_prev   = we_b;
      done_prev = done;
      cpu_prev  = cpu_rst;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(!bad_stop);
    if (bad_stop) send_bit(1'b1);
    repeat ($urandom_range(0, CPB)) @(negedge clk);
  endtask

  task automatic send_glitch();
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_addr_b", 32'(addr_b), 32'd0);
    check_eq("rst_data_b", 32'(data_b), 32'd0);
    check_eq("rst_we_b", 32'(we_b), 32'd0);
    check_eq("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  function automatic byte_q_t build_frame(input logic [15:0] words[$]);
    byte_q_t     f;
    logic [7:0]  x;
    logic [15:0] n;
    n = 16'(words.size());
    x = 8'h00;
    f.push_back(n[15:8]);
    f.push_back(n[7:0]);
    foreach (words[i]) begin
      f.push_back(words[i][15:8]);
      f.push_back(words[i][7:0]);
      x = x ^ words[i][15:8] ^ words[i][7:0];
    end
`ifdef UART_LOADER_CHECKSUM_EN
    f.push_back(x);
`endif
    return f;
  endfunction

  // Sends a frame (optionally corrupting byte bad_idx once, then resending it) and checks the outcome
  task automatic run_frame(input string name, input byte_q_t frame, input int bad_idx);
    int          start;
    int          run0;
    int          n;
    int          nw;
    int          got_n;
    bit          exp_err;
    bit          seen_done;
    logic [7:0]  x;
    logic [31:0] exp_w;
    start = wr_q.size();
    run0  = we_run_err;
    foreach (frame[i]) begin
      if (i == bad_idx) send_byte(frame[i], 1'b1);
      send_byte(frame[i], 1'b0);
    end
    seen_done = 1'b0;
    for (int t = 0; t < 4 * CPB; t++) begin
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);

    n = {frame[0], frame[1]};
    exp_err = (bad_idx >= 0);
    if (n > MAXW) begin
      exp_err = 1'b1;
      nw = 0;
    end else begin
      nw = n;
`ifdef UART_LOADER_CHECKSUM_EN
      x = 8'h00;
      for (int i = 0; i < 2 * n; i++) x = x ^ frame[2 + i];
      if (x != frame[2 + 2 * n]) exp_err = 1'b1;
`endif
    end

    got_n = wr_q.size() - start;
    check_eq({name, "_done_seen"}, 32'(seen_done), 32'd1);
    check_eq({name, "_done"}, 32'(done), 32'd1);
    check_eq({name, "_err"}, 32'(err), 32'(exp_err));
    check_eq({name, "_cpu_rst"}, 32'(cpu_rst), 32'(exp_err));
    check_eq({name, "_nwrites"}, 32'(got_n), 32'(nw));
    check_eq({name, "_we_width"}, 32'(we_run_err - run0), 32'd0);
    for (int i = 0; i < nw; i++) begin
      exp_w = {16'(i), frame[2 + 2 * i], frame[3 + 2 * i]};
      if (i < got_n) check_eq({name, "_write"}, wr_q[start + i], exp_w);
    end
    if (!exp_err) check_eq({name, "_cpu_rel_lat"}, 32'(cpu_fall - done_rise), 32'd1);
    $display("frame %s: N=%0d writes=%0d err=%0b done=%0b cpu_rst=%0b", name, n, got_n, err, done, cpu_rst);
  endtask

  initial begin
    logic [15:0] w[$];
    byte_q_t     f;
    int          start;

    do_reset();

    w = {16'h1234, 16'hABCD};
    run_frame("two_words", build_frame(w), -1);

    do_reset();
    w = {};
    run_frame("empty", build_frame(w), -1);

    do_reset();
    f = {8'h04, 8'h01};
    run_frame("oversize", f, -1);

    do_reset();
    w = {16'h1234, 16'hABCD};
    run_frame("ferr_resend", build_frame(w), 2);

    // Abort mid-load: one word of three written, then reset and reload
    do_reset();
    start = wr_q.size();
    f = {8'h00, 8'h03, 8'h11, 8'h22};
    foreach (f[i]) send_byte(f[i], 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check_eq("abort_nwrites", 32'(wr_q.size() - start), 32'd1);
    if (wr_q.size() > start) check_eq("abort_write", wr_q[start], 32'h0000_1122);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    $display("frame abort: partial load of 3 words, writes=%0d", wr_q.size() - start);
    do_reset();
    w = {16'h5566};
    run_frame("after_abort", build_frame(w), -1);

`ifdef UART_LOADER_CHECKSUM_EN
    do_reset();
    f = {8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
    run_frame("chk_good", f, -1);
    do_reset();
    f = {8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
    run_frame("chk_bad", f, -1);
`endif

    for (int r = 0; r < 4; r++) begin
      int nwords;
      do_reset();
      send_glitch();
      nwords = $urandom_range(1, 10);
      w = {};
      for (int k = 0; k < nwords; k++) w.push_back(16'($urandom));
      f = build_frame(w);
      run_frame($sformatf("rand%0d", r), f, (r == 2) ? int'($urandom_range(0, f.size() - 1)) : -1);
    end

    // Bytes after DONE must not cause writes or status changes
    start = wr_q.size();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check_eq("post_done_writes", 32'(wr_q.size() - start), 32'd0);
    check_eq("post_done_done", 32'(done), 32'd1);
    $display("frame post_done: 4 bytes ignored, writes=%0d", wr_q.size() - start);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
